writereg_unit: RTL and testbench
================================

# writereg_unit

Parametrised register-destination unit for the multicycle datapath. It selects the write-back register address from the instruction fields or the fixed link/stack registers, and registers that address at decode so later instruction-register changes cannot corrupt it. It also tracks up to DEPTH in-flight writes (multicycle loads, mult/div, pending write-back) in a FIFO scoreboard. Source-register conflicts raise a hazard for the control FSM, so the block replaces the purely combinational write-register mux.

## Interface
Parameters:
- ADDR_W, 5, register-address width
- INSTR_W, 16, width of the instruction slice on `instr_lo`
- RD_LSB, 11, bit position of the rd field inside `instr_lo`
- LINK_REG, 31, address driven in LINK mode
- STACK_REG, 29, address driven in STACK mode
- DEPTH, 4, maximum outstanding writes (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sel  in  4  destination mode: 0 RT, 1 RD, 2 LINK, 3 STACK, others ZERO
- rt_field  in  ADDR_W  rt field of the current instruction
- instr_lo  in  INSTR_W  low instruction slice; rd = instr_lo[RD_LSB +: ADDR_W]
- capture  in  1  latch the selected address into `wr_addr`
- issue_valid  in  1  record `wr_addr` as an outstanding write
- issue_ready  out  1  scoreboard can accept an issue this cycle
- retire  in  1  oldest outstanding write has completed
- rs_q, rt_q  in  ADDR_W  source addresses to check
- wr_addr  out  ADDR_W  registered destination address
- hazard  out  1  rs_q or rt_q matches a stored non-zero entry
- pending_cnt  out  $clog2(DEPTH+1)  number of outstanding entries
- underflow  out  1  sticky: `retire` was seen while the scoreboard was empty

## Operation
- Mode decode (combinational, `next_addr`):
  - RT → `rt_field`
  - RD → rd slice of `instr_lo`
  - LINK → LINK_REG
  - STACK → STACK_REG
  - any other code → 0
- `wr_addr`:
  - loads `next_addr` on the edge where `capture`=1
  - otherwise holds its value
- Scoreboard: in-order circular FIFO of DEPTH entries, with write pointer, read pointer and count.
  - Issue:
    - accepted when `issue_valid && issue_ready`
    - stores the current registered `wr_addr`, including 0, so retire order stays aligned
    - an issue in the same cycle as `capture` stores the pre-capture value
  - Retire: pops the oldest entry.
  - `issue_ready` = (count < DEPTH) || retire.
    - Simultaneous issue+retire when full is legal.
    - Count is unchanged and pointers advance.
  - Issue with `issue_ready`=0: ignored, no state change.
  - Retire when count=0:
    - ignored
    - `underflow` set to 1 and held until reset
    - a simultaneous issue still pushes
- `hazard` (combinational):
  - OR over valid entries of (entry≠0 && (entry==rs_q || entry==rt_q))
  - considers stored entries only; a same-cycle issue is not visible
  - register 0 never raises a hazard
- Pointer wrap: modulo DEPTH; DEPTH need not be a power of two.

## Timing
- Reset values: `wr_addr`=0, count=0, both pointers=0, `pending_cnt`=0, `hazard`=0, `issue_ready`=1, `underflow`=0.
- Reset asserted mid-operation drops all outstanding entries immediately (asynchronous).
- `capture` → `wr_addr` valid 1 cycle later.
- Issue → entry visible in `hazard` and `pending_cnt` the next cycle.
- Retire → entry removed and `hazard` clears the next cycle, provided no other matching entry remains.
- `issue_ready` and `hazard` are combinational from state plus `retire`, `rs_q`, `rt_q`.

## Structure
- Shared package `writereg_pkg`: mode constants WRSEL_RT=4'h0, WRSEL_RD=4'h1, WRSEL_LINK=4'h2, WRSEL_STACK=4'h3.
- Sub-module `writereg_scoreboard`:
  - contains the FIFO, count, underflow and hazard compare
  - parameters ADDR_W and DEPTH
- Top level `writereg_unit`: mode decode plus the `wr_addr` register.

## Test plan
- Reset, then sel=1, instr_lo=16'h4800, capture → `wr_addr`=9 next cycle; with capture=0 and instr_lo changed, `wr_addr` stays 9.
- sel=2 capture, then sel=3 capture, then sel=4'h7 capture → `wr_addr`=31, then 29, then 0; with STACK_REG=30 override, sel=3 → 30.
- Issue 5, 6, 7, 8 (DEPTH=4):
  - `pending_cnt`=4 and `issue_ready`=0
  - a 5th issue without retire is ignored
  - issue+retire in the same cycle → count stays 4, and the oldest entry 5 is replaced by 9 at the tail
- Entries {0, 12}:
  - rs_q=0, rt_q=0 → `hazard`=0
  - rt_q=12 → `hazard`=1
  - retire twice → `hazard`=0 and `pending_cnt`=0
- Retire on empty → `underflow`=1 and count stays 0; underflow stays set through later activity until reset.
- Async reset mid-stream with 3 entries pending → `pending_cnt`=0, `hazard`=0, `wr_addr`=0 with no clock edge required.

Source files
------------

// File: rtl/writereg_pkg.sv
// Shared definitions for the write-register destination unit.
//   WRSEL_* : destination-mode codes driven on `sel`.
//   Codes other than those listed select register 0.
package writereg_pkg;
  localparam logic [3:0] WRSEL_RT    = 4'h0;
  localparam logic [3:0] WRSEL_RD    = 4'h1;
  localparam logic [3:0] WRSEL_LINK  = 4'h2;
  localparam logic [3:0] WRSEL_STACK = 4'h3;
endpackage

// File: rtl/writereg_scoreboard.sv
// In-order scoreboard of outstanding register writes.
//   push_valid/push_addr/push_ready : enqueue a destination address
//   pop_req     : oldest write completed (ignored when empty)
//   rs_q, rt_q  : source addresses checked against stored entries
//   hazard      : a stored non-zero entry matches rs_q or rt_q
//   count       : number of stored entries
//   underflow   : sticky, pop_req seen while empty
module writereg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              push_ready,
  input  logic              pop_req,
  input  logic [ADDR_W-1:0] rs_q,
  input  logic [ADDR_W-1:0] rt_q,
  output logic              hazard,
  output logic [CW-1:0]     count,
  output logic              underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0]             hit;
  logic [PW-1:0]                wptr, rptr;
  logic                         push, pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A same-cycle retire frees a slot, so a full FIFO can still accept.
  assign push_ready = (count != CW'(DEPTH)) || pop_req;
  assign push       = push_valid && push_ready;
  assign pop        = pop_req && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem       <= '0;
      vld       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= ptr_inc(rptr);
      end
      // Push after pop: when full, both pointers hit the same slot and
      // the new entry must stay valid.
      if (push) begin
        mem[wptr] <= push_addr;
        vld[wptr] <= 1'b1;
        wptr      <= ptr_inc(wptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (pop_req && (count == '0)) underflow <= 1'b1;
    end
  end

  // Register 0 is a write sink and never a real dependency.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit[i] = vld[i] && (mem[i] != '0) &&
                    ((mem[i] == rs_q) || (mem[i] == rt_q));
  end
  assign hazard = |hit;
endmodule

// File: rtl/writereg_unit.sv
// Write-back destination unit for the multicycle datapath.
//   sel/rt_field/instr_lo : destination mode and instruction fields
//   capture     : latch the decoded destination into wr_addr
//   issue_valid/issue_ready : record wr_addr as an outstanding write
//   retire      : oldest outstanding write completed
//   rs_q, rt_q  : source addresses checked for hazards
//   wr_addr     : registered destination address
//   hazard, pending_cnt, underflow : scoreboard status
module writereg_unit
  import writereg_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int INSTR_W   = 16,
  parameter int RD_LSB    = 11,
  parameter int LINK_REG  = 31,
  parameter int STACK_REG = 29,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 sel,
  input  logic [ADDR_W-1:0]          rt_field,
  input  logic [INSTR_W-1:0]         instr_lo,
  input  logic                       capture,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       retire,
  input  logic [ADDR_W-1:0]          rs_q,
  input  logic [ADDR_W-1:0]          rt_q,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       hazard,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
  output logic                       underflow
);
  logic [ADDR_W-1:0] next_addr;
  logic              unused_instr;

  // Only the rd slice is consumed; the rest of the slice is ignored.
  assign unused_instr = ^instr_lo;

  always_comb begin
    next_addr = '0;
    case (sel)
      WRSEL_RT:    next_addr = rt_field;
      WRSEL_RD:    next_addr = instr_lo[RD_LSB +: ADDR_W];
      WRSEL_LINK:  next_addr = ADDR_W'(LINK_REG);
      WRSEL_STACK: next_addr = ADDR_W'(STACK_REG);
      default:     next_addr = '0;
    endcase
  end

  // Holding the destination here decouples it from later IR changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        wr_addr <= '0;
    else if (capture) wr_addr <= next_addr;
  end

  // The scoreboard sees the pre-capture wr_addr on a same-cycle issue.
  writereg_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push_valid (issue_valid),
    .push_addr  (wr_addr),
    .push_ready (issue_ready),
    .pop_req    (retire),
    .rs_q       (rs_q),
    .rt_q       (rt_q),
    .hazard     (hazard),
    .count      (pending_cnt),
    .underflow  (underflow)
  );
endmodule

// File: tb/tb_writereg_unit.sv
module tb_writereg_unit;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    sel;
  logic [AW-1:0] rt_field, rs_q, rt_q;
  logic [15:0]   instr_lo;
  logic          capture, issue_valid, retire;
  logic          issue_ready, hazard, underflow;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] pending_cnt;
  logic          issue_ready2, hazard2, underflow2;
  logic [AW-1:0] wr_addr2;
  logic [CW-1:0] pending_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of outstanding destinations.
  int mq[$];
  int mwr  = 0;
  int mwr2 = 0;
  bit muf  = 1'b0;

  writereg_unit #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .sel(sel), .rt_field(rt_field),
    .instr_lo(instr_lo), .capture(capture), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .retire(retire), .rs_q(rs_q), .rt_q(rt_q),
    .wr_addr(wr_addr), .hazard(hazard), .pending_cnt(pending_cnt),
    .underflow(underflow)
  );

  writereg_unit #(.DEPTH(DEPTH), .STACK_REG(30)) u_dut2 (
    .clk(clk), .reset(reset), .sel(sel), .rt_field(rt_field),
    .instr_lo(instr_lo), .capture(capture), .issue_valid(issue_valid),
    .issue_ready(issue_ready2), .retire(retire), .rs_q(rs_q), .rt_q(rt_q),
    .wr_addr(wr_addr2), .hazard(hazard2), .pending_cnt(pending_cnt2),
    .underflow(underflow2)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int s, int rtf, int il, int stk);
    case (s)
      0:       return rtf;
      1:       return (il >> 11) & 31;
      2:       return 31;
      3:       return stk;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_hazard(int rs, int rt);
    foreach (mq[i])
      if (mq[i] != 0 && (mq[i] == rs || mq[i] == rt)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit rdy;
    rdy = (mq.size() < DEPTH) || retire;
    chk("wr_addr", wr_addr, mwr);
    chk("wr_addr_stk30", wr_addr2, mwr2);
    chk("pending_cnt", pending_cnt, mq.size());
    chk("issue_ready", issue_ready, rdy);
    chk("hazard", hazard, model_hazard(rs_q, rt_q));
    chk("underflow", underflow, muf);
  endtask

  // Inputs are set at posedge+1; check pre-edge outputs, then advance model.
  task automatic cycle();
    bit rdy;
    int old_wr;
    #2 check_all();
    @(posedge clk);
    old_wr = mwr;
    rdy = (mq.size() < DEPTH) || retire;
    if (retire) begin
      if (mq.size() == 0) muf = 1'b1;
      else void'(mq.pop_front());
    end
    if (issue_valid && rdy) mq.push_back(old_wr);
    if (capture) begin
      mwr  = model_next(sel, rt_field, instr_lo, 29);
      mwr2 = model_next(sel, rt_field, instr_lo, 30);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = '0; rt_field = '0; instr_lo = '0; capture = 1'b0;
    issue_valid = 1'b0; retire = 1'b0; rs_q = '0; rt_q = '0;
    #12;
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_underflow", underflow, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Mode decode and capture/hold.
    sel = 4'h1; instr_lo = 16'h4800; capture = 1'b1; cycle();
    capture = 1'b0; instr_lo = 16'hFFFF;
    chk("rd_capture", wr_addr, 9);
    cycle();
    chk("rd_hold", wr_addr, 9);
    sel = 4'h2; capture = 1'b1; cycle();
    chk("link", wr_addr, 31);
    sel = 4'h3; cycle();
    chk("stack", wr_addr, 29);
    chk("stack_ovr", wr_addr2, 30);
    sel = 4'h7; cycle();
    chk("zero_mode", wr_addr, 0);

    // Fill with 5,6,7,8; each issue overlaps the next capture.
    sel = 4'h0; rt_field = 5; cycle();
    rt_field = 6; issue_valid = 1'b1; cycle();
    rt_field = 7; cycle();
    rt_field = 8; cycle();
    capture = 1'b0; cycle();
    chk("full_cnt", pending_cnt, 4);
    chk("full_ready", issue_ready, 0);
    cycle();
    chk("full_ignore", pending_cnt, 4);
    rt_field = 9; capture = 1'b1; issue_valid = 1'b0; cycle();
    capture = 1'b0; issue_valid = 1'b1; retire = 1'b1;
    #1 chk("full_ready_ret", issue_ready, 1);
    cycle();
    issue_valid = 1'b0; retire = 1'b0;
    chk("swap_cnt", pending_cnt, 4);
    rs_q = 5; rt_q = 0;
    #1 chk("swap_old_gone", hazard, 0);
    rs_q = 9;
    #1 chk("swap_new_tail", hazard, 1);
    retire = 1'b1;
    repeat (4) cycle();
    retire = 1'b0;

    // Entries {0,12}.
    sel = 4'h7; capture = 1'b1; cycle();
    sel = 4'h0; rt_field = 12; issue_valid = 1'b1; cycle();
    capture = 1'b0; cycle();
    issue_valid = 1'b0; rs_q = 0; rt_q = 0;
    #1 chk("zero_no_hazard", hazard, 0);
    rt_q = 12;
    #1 chk("rt12_hazard", hazard, 1);
    retire = 1'b1; cycle(); cycle();
    retire = 1'b0;
    #1 chk("drained_hazard", hazard, 0);
    chk("drained_cnt", pending_cnt, 0);

    // Retire on empty.
    retire = 1'b1; cycle();
    retire = 1'b0;
    chk("underflow_set", underflow, 1);
    chk("underflow_cnt", pending_cnt, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sel         = 4'($urandom_range(0, 7));
      rt_field    = AW'($urandom);
      instr_lo    = 16'($urandom);
      capture     = ($urandom_range(0, 2) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      retire      = ($urandom_range(0, 9) < 4);
      rs_q        = AW'($urandom);
      rt_q        = AW'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        rs_q = AW'(mq[$urandom_range(0, mq.size() - 1)]);
      cycle();
    end

    // Async reset with three writes pending.
    capture = 1'b0; issue_valid = 1'b0; retire = 1'b1;
    repeat (DEPTH) cycle();
    retire = 1'b0; sel = 4'h0; rt_field = 3; capture = 1'b1; cycle();
    capture = 1'b0; issue_valid = 1'b1;
    repeat (3) cycle();
    issue_valid = 1'b0; rs_q = 3; rt_q = 0;
    #1 chk("pre_rst_cnt", pending_cnt, 3);
    chk("pre_rst_hazard", hazard, 1);
    reset = 1'b1;
    #1 chk("arst_cnt", pending_cnt, 0);
    chk("arst_hazard", hazard, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_underflow", underflow, 0);
    mq.delete(); mwr = 0; mwr2 = 0; muf = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      sel         = 4'($urandom_range(0, 4));
      rt_field    = AW'($urandom);
      instr_lo    = 16'($urandom);
      capture     = $urandom_range(0, 1);
      issue_valid = $urandom_range(0, 1);
      retire      = ($urandom_range(0, 3) == 0);
      rs_q        = AW'($urandom);
      rt_q        = AW'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
